// File: rtl/flash_page_packer_if.sv
// ============================================================================
// Module   : flash_page_packer_if
// Brief    : Byte-in / word-out valid-ready bus of the flash page packer.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface flash_page_packer_if #(
  parameter int DSIZE = 8,
  parameter int OSIZE = 32
);
  logic             in_valid;
  logic [DSIZE-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [OSIZE-1:0] out_data;
  logic             out_last;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

`default_nettype wire

// File: rtl/flash_page_packer.sv
// ============================================================================
// Module   : flash_page_packer
// Brief    : Drops SPI flash echo bytes and packs page payload into words.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module flash_page_packer #(
  parameter int DSIZE      = 8,
  parameter int OSIZE      = 32,
  parameter int SKIP_NUM   = 9,
  parameter int PAGE_BYTES = 256,
  parameter int MSB_FIRST  = 1
) (
  input  wire                  clock,
  input  wire                  rst_n,
  input  wire                  frame_flag,
  flash_page_packer_if.slave   bus,
  output logic                 page_done,
  output logic                 abort,
  output logic                 stray
);

  localparam int c_lanes     = OSIZE / DSIZE;
  localparam int c_lw        = (c_lanes > 1) ? $clog2(c_lanes) : 1;
  localparam int c_bw        = $clog2(PAGE_BYTES + 1);
  localparam int c_sw        = (SKIP_NUM > 1) ? $clog2(SKIP_NUM) : 1;
  localparam int c_skip_last = (SKIP_NUM > 0) ? SKIP_NUM - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_PACK  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           r_state;
  logic [c_sw-1:0]  r_skip_cnt;
  logic [c_lw-1:0]  r_lane_cnt;
  logic [c_bw-1:0]  r_byte_cnt;
  logic [OSIZE-1:0] r_acc;
  logic [OSIZE-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_take;
  logic             w_lane_last;
  logic [c_bw-1:0]  w_byte_next;
  logic [OSIZE-1:0] w_word;

  assign w_lane_last = (r_lane_cnt == c_lw'(c_lanes - 1));
  assign w_byte_next = r_byte_cnt + c_bw'(1);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_take      = r_out_valid && bus.out_ready;

  // The completing byte may only enter when the output register is free or emptying.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_IDLE, ST_SKIP: w_in_ready = 1'b1;
      ST_PACK:          w_in_ready = !w_lane_last || !r_out_valid || bus.out_ready;
      default:          w_in_ready = 1'b0;
    endcase
  end

  always_comb begin
    w_word = r_acc;
    for (int i = 0; i < c_lanes; i++) begin
      if (r_lane_cnt == c_lw'(i)) begin
        w_word[((MSB_FIRST != 0) ? (c_lanes - 1 - i) : i) * DSIZE +: DSIZE] = bus.in_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_skip_cnt  <= '0;
      r_lane_cnt  <= '0;
      r_byte_cnt  <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      page_done   <= 1'b0;
      abort       <= 1'b0;
      stray       <= 1'b0;
    end else begin
      page_done <= 1'b0;
      abort     <= 1'b0;
      stray     <= 1'b0;

      if (w_take) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end

      if (frame_flag) begin
        // A relaunch restarts the page; any byte in this cycle is discarded.
        if (r_state != ST_IDLE) begin
          abort       <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_out_data  <= '0;
        end else if (w_accept) begin
          stray <= 1'b1;
        end
        r_acc      <= '0;
        r_skip_cnt <= '0;
        r_lane_cnt <= '0;
        r_byte_cnt <= '0;
        r_state    <= (SKIP_NUM == 0) ? ST_PACK : ST_SKIP;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) stray <= 1'b1;
          end
          ST_SKIP: begin
            if (w_accept) begin
              r_skip_cnt <= r_skip_cnt + c_sw'(1);
              if (r_skip_cnt == c_sw'(c_skip_last)) begin
                r_state    <= ST_PACK;
                r_lane_cnt <= '0;
                r_byte_cnt <= '0;
              end
            end
          end
          ST_PACK: begin
            if (w_accept) begin
              r_byte_cnt <= w_byte_next;
              if (w_lane_last) begin
                r_lane_cnt  <= '0;
                r_acc       <= '0;
                r_out_data  <= w_word;
                r_out_valid <= 1'b1;
                r_out_last  <= (w_byte_next == c_bw'(PAGE_BYTES));
                if (w_byte_next == c_bw'(PAGE_BYTES)) r_state <= ST_DRAIN;
              end else begin
                r_lane_cnt <= r_lane_cnt + c_lw'(1);
                r_acc      <= w_word;
              end
            end
          end
          ST_DRAIN: begin
            if (w_take && r_out_last) begin
              page_done <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_flash_page_packer.sv
// ============================================================================
// Module   : tb_flash_page_packer
// Brief    : Directed self-checking bench for flash_page_packer.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_flash_page_packer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_n      = 1'b0;
  logic frame_flag = 1'b0;
  logic frame_flag2 = 1'b0;
  logic page_done, abort, stray;
  logic page_done2, abort2, stray2;
  logic r_ord = 1'b1;

  flash_page_packer_if #(.DSIZE(8), .OSIZE(32)) bus ();
  flash_page_packer_if #(.DSIZE(8), .OSIZE(32)) bus2 ();

  assign bus.out_ready = r_ord;

  flash_page_packer dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .frame_flag (frame_flag),
    .bus        (bus),
    .page_done  (page_done),
    .abort      (abort),
    .stray      (stray)
  );

  flash_page_packer #(.MSB_FIRST(0)) dut_lsb (
    .clock      (clock),
    .rst_n      (rst_n),
    .frame_flag (frame_flag2),
    .bus        (bus2),
    .page_done  (page_done2),
    .abort      (abort2),
    .stray      (stray2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int w);
    return {8'(4 * w), 8'(4 * w + 1), 8'(4 * w + 2), 8'(4 * w + 3)};
  endfunction

  // Scoreboard: every word on the bus is compared against the 0x00..0xFF page model.
  int   wcnt = 0, pd_cnt = 0, ab_cnt = 0, st_cnt = 0, blk_cnt = 0;
  logic last_prev = 1'b0;

  always @(negedge clock) begin
    if (!rst_n) begin
      wcnt      = 0;
      last_prev = 1'b0;
    end else begin
      if (last_prev || page_done) check("page_done", page_done, last_prev);
      last_prev = 1'b0;
      if (page_done) begin
        pd_cnt++;
        check("words_per_page", wcnt, 64);
        wcnt = 0;
      end
      if (abort) begin
        ab_cnt++;
        wcnt = 0;
      end
      if (stray) st_cnt++;
      if (bus.in_valid && !bus.in_ready) blk_cnt++;
      if (bus.out_valid) begin
        check("out_data", bus.out_data, exp_word(wcnt));
        check("out_last", bus.out_last, wcnt == 63);
        if (bus.out_ready) begin
          last_prev = bus.out_last;
          wcnt++;
        end
      end
    end
  end

  // Back-pressure on word 5, for 10 clock edges, once.
  int   stall_req  = 0;
  int   stall_left = 0;
  logic stall_done = 1'b0;

  always @(posedge clock) begin
    #1;
    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) r_ord = 1'b1;
    end else if (stall_req != 0 && !stall_done && bus.out_valid && wcnt == 5) begin
      r_ord      = 1'b0;
      stall_left = 10;
      stall_done = 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int   n   = 0;
    logic rdy = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!rdy && n < 1000) begin
      @(negedge clock);
      rdy = bus.in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!rdy) check("send_timeout", rdy, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_flag();
    frame_flag = 1'b1;
    @(posedge clock);
    #1;
    frame_flag = 1'b0;
  endtask

  task automatic send_payload(input int nbytes);
    for (int i = 0; i < 9; i++) send_byte(8'hEE);
    for (int i = 0; i < nbytes; i++) send_byte(8'(i));
  endtask

  task automatic wait_done(input int pd0);
    int n = 0;
    while (pd_cnt == pd0 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("page_done_seen", pd_cnt, pd0 + 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_last"},  bus.out_last, 0);
    check({tag, "_out_data"},  bus.out_data, 0);
    check({tag, "_page_done"}, page_done, 0);
    check({tag, "_abort"},     abort, 0);
    check({tag, "_stray"},     stray, 0);
    check({tag, "_in_ready"},  bus.in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pd0, ab0, st0, b0;
    logic [7:0] lsb_bytes [13];
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.out_ready = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clock);
    #1;

    // T1: plain page, full throughput
    pd0 = pd_cnt;
    pulse_flag();
    send_payload(256);
    wait_done(pd0);

    // T2: stall on word 5
    stall_req = 1;
    b0  = blk_cnt;
    pd0 = pd_cnt;
    pulse_flag();
    send_payload(256);
    wait_done(pd0);
    check("stall_applied", stall_done, 1);
    check("stall_in_ready_low", blk_cnt > b0, 1);

    // T3: LSB-first packing on the second instance
    for (int i = 0; i < 9; i++) lsb_bytes[i] = 8'hEE;
    for (int i = 0; i < 4; i++) lsb_bytes[9 + i] = 8'hA0 + 8'(i);
    frame_flag2 = 1'b1;
    @(posedge clock);
    #1;
    frame_flag2   = 1'b0;
    bus2.in_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bus2.in_data = lsb_bytes[i];
      @(posedge clock);
      #1;
    end
    bus2.in_valid = 1'b0;
    check("lsb_out_valid", bus2.out_valid, 1);
    check("lsb_out_data", bus2.out_data, 32'hA3A2A1A0);

    // T4: relaunch after 100 payload bytes
    pd0 = pd_cnt;
    ab0 = ab_cnt;
    pulse_flag();
    send_payload(100);
    pulse_flag();
    check("abort_pulse", abort, 1);
    check("abort_out_valid", bus.out_valid, 0);
    send_payload(256);
    wait_done(pd0);
    repeat (5) @(posedge clock);
    #1;
    check("abort_count", ab_cnt - ab0, 1);
    check("abort_single_done", pd_cnt - pd0, 1);

    // T5: bytes with no launch are strays
    st0 = st_cnt;
    for (int i = 0; i < 3; i++) send_byte(8'h55);
    repeat (2) @(posedge clock);
    #1;
    check("stray_count", st_cnt - st0, 3);
    check("stray_no_words", wcnt, 0);
    pd0 = pd_cnt;
    pulse_flag();
    send_payload(256);
    wait_done(pd0);

    // T6: reset in the middle of a page
    pd0 = pd_cnt;
    ab0 = ab_cnt;
    pulse_flag();
    send_payload(40);
    rst_n = 1'b0;
    @(posedge clock);
    #1;
    check_reset("mid_reset");
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    check("mid_reset_no_done", pd_cnt - pd0, 0);
    pulse_flag();
    send_payload(256);
    wait_done(pd0);
    check("mid_reset_no_abort", ab_cnt - ab0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
